// File: rtl/fft_reorder_out.sv
// Dual-path FFT output reorder: bit-reversed beats in, 32 natural-order bins out via ping-pong banks.
// Optional `define FFT_REORDER_OVF_EN adds a sticky overflow flag for dropped frames.
module fft_reorder_out #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_up_re,
    input  logic [WIDTH-1:0] in_up_im,
    input  logic [WIDTH-1:0] in_l_re,
    input  logic [WIDTH-1:0] in_l_im,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_index,
    output logic             out_last
`ifdef FFT_REORDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    logic [3:0]         wr_k;
    logic               wr_bank;
    logic               rd_bank;
    logic [1:0]         full;
    logic [1:0]         full_next;
    logic [4:0]         rd_idx;
    logic               drop_frame;
    logic               frame_drop_now;
    logic               dropping;
    logic               wr_en;
    logic               frame_done;
    logic               rd_fire;
    logic               rd_wrap;
    logic [3:0]         wr_addr;
    logic [2*WIDTH-1:0] rd_word;

    // Upper-path bins (0..15) and lower-path bins (16..31) live in separate halves,
    // so each half needs only one write port per beat.
    logic [2*WIDTH-1:0] up_mem [2][16];
    logic [2*WIDTH-1:0] lo_mem [2][16];

    // The keep/drop decision is taken once at k=0 and held for the whole frame.
    assign frame_drop_now = in_valid && (wr_k == 4'd0) && (full == 2'b11);
    assign dropping       = (wr_k == 4'd0) ? frame_drop_now : drop_frame;
    assign wr_en          = in_valid && !dropping;
    assign frame_done     = wr_en && (wr_k == 4'd15);
    assign wr_addr        = {wr_k[0], wr_k[1], wr_k[2], wr_k[3]};

    // Output handshake: a bin transfers on any cycle where out_valid and out_ready are both
    // high; while out_valid is high and out_ready low, the presented bin and data hold.
    assign rd_fire = out_valid && out_ready;
    assign rd_wrap = rd_fire && (rd_idx == 5'd31);

    always_comb begin
        full_next = full;
        if (frame_done) full_next[wr_bank] = 1'b1;
        if (rd_wrap)    full_next[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_k       <= 4'd0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            full       <= 2'b00;
            rd_idx     <= 5'd0;
            drop_frame <= 1'b0;
        end else begin
            if (in_valid) begin
                wr_k <= wr_k + 4'd1;
                if (wr_k == 4'd0) drop_frame <= frame_drop_now;
            end
            if (frame_done) wr_bank <= ~wr_bank;
            full <= full_next;
            if (rd_fire) begin
                rd_idx <= rd_idx + 5'd1;
                if (rd_wrap) rd_bank <= ~rd_bank;
            end
        end
    end

`ifdef FFT_REORDER_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (frame_drop_now) begin
            overflow <= 1'b1;
        end
    end
`endif

    // Bank contents need no reset; full flags alone decide what is readable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            up_mem[wr_bank][wr_addr] <= {in_up_re, in_up_im};
            lo_mem[wr_bank][wr_addr] <= {in_l_re, in_l_im};
        end
    end

    assign rd_word   = rd_idx[4] ? lo_mem[rd_bank][rd_idx[3:0]] : up_mem[rd_bank][rd_idx[3:0]];
    assign out_re    = rd_word[2*WIDTH-1:WIDTH];
    assign out_im    = rd_word[WIDTH-1:0];
    assign out_valid = full[rd_bank];
    assign out_index = rd_idx;
    assign out_last  = (rd_idx == 5'd31);

endmodule

// File: tb/tb_fft_reorder_out.sv
// Self-checking bench for fft_reorder_out: scoreboard of natural-order bins plus per-scenario checks.
module tb_fft_reorder_out;

    localparam int W  = 10;
    localparam int EW = 1 + 5 + 2 * W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_up_re;
    logic [W-1:0] in_up_im;
    logic [W-1:0] in_l_re;
    logic [W-1:0] in_l_im;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   out_index;
    logic         out_last;
`ifdef FFT_REORDER_OVF_EN
    logic         overflow;
`endif

    logic [EW-1:0] exp_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    logic          watch_valid = 1'b0;
    int            valid_gaps  = 0;
    logic          pre_last_valid;

    always #5 clk = ~clk;

    fft_reorder_out #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_up_re  (in_up_re),
        .in_up_im  (in_up_im),
        .in_l_re   (in_l_re),
        .in_l_im   (in_l_im),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last)
`ifdef FFT_REORDER_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    // Scoreboard: every accepted output bin is popped against the expected queue.
    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        logic [EW-1:0] g;
        if (!rst && watch_valid && !out_valid) valid_gaps++;
        if (!rst && out_valid && out_ready) begin
            vectors++;
            g = {out_last, out_index, out_re, out_im};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output: got idx=%0d re=%0h im=%0h, expected no output",
                         out_index, out_re, out_im);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard: got last=%0b idx=%0d re=%0h im=%0h, expected last=%0b idx=%0d re=%0h im=%0h",
                             g[EW-1], g[EW-2 -: 5], g[2*W-1:W], g[W-1:0],
                             e[EW-1], e[EW-2 -: 5], e[2*W-1:W], e[W-1:0]);
                end
            end
        end
    end

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

    // Driver: mode 0 = bitrev pattern on re, mode 1 = random; gap idle cycles after each beat.
    task automatic send_frame(input int mode, input int gap, input bit push, input int nbeats);
        logic [W-1:0] ur[16], ui[16], lr[16], li[16];
        logic [W-1:0] br[32], bi[32];
        logic [4:0]   b;
        for (int k = 0; k < 16; k++) begin
            b = bitrev5(5'(2 * k));
            if (mode == 0) begin
                ur[k] = W'(b);
                lr[k] = W'(b) + W'(16);
            end else begin
                ur[k] = W'($urandom_range(0, (1 << W) - 1));
                lr[k] = W'($urandom_range(0, (1 << W) - 1));
            end
            ui[k] = W'($urandom_range(0, (1 << W) - 1));
            li[k] = W'($urandom_range(0, (1 << W) - 1));
            br[int'(b)]      = ur[k];
            bi[int'(b)]      = ui[k];
            br[int'(b) + 16] = lr[k];
            bi[int'(b) + 16] = li[k];
        end
        if (push) begin
            for (int i = 0; i < 32; i++) exp_q.push_back({(i == 31), 5'(i), br[i], bi[i]});
        end
        for (int k = 0; k < nbeats; k++) begin
            if (k == 15) pre_last_valid = out_valid;
            in_valid = 1'b1;
            in_up_re = ur[k];
            in_up_im = ui[k];
            in_l_re  = lr[k];
            in_l_im  = li[k];
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid: got %b, expected 0", out_valid);
        end
        vectors++;
        if (out_index !== 5'd0) begin
            miscompares++; $display("FAIL reset_index: got %0d, expected 0", out_index);
        end
        vectors++;
        if (out_last !== 1'b0) begin
            miscompares++; $display("FAIL reset_last: got %b, expected 0", out_last);
        end
`ifdef FFT_REORDER_OVF_EN
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++; $display("FAIL reset_overflow: got %b, expected 0", overflow);
        end
`endif
    endtask

    task automatic test_single_frame(input int gap, input string name);
        out_ready = 1'b1;
        send_frame(0, gap, 1'b1, 16);
        vectors++;
        if (pre_last_valid !== 1'b0) begin
            miscompares++; $display("FAIL %s_early_valid: got %b before beat 15, expected 0", name, pre_last_valid);
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++; $display("FAIL %s_valid_rise: got %b after beat 15, expected 1", name, out_valid);
        end
        wait_drain(100);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL %s_drain: got %0d bins left, expected 0", name, exp_q.size());
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL %s_idle_valid: got %b, expected 0", name, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready  = 1'b1;
        valid_gaps = 0;
        send_frame(1, 0, 1'b1, 16);
        watch_valid = 1'b1;
        send_frame(1, 0, 1'b1, 16);
        wait_drain(200);
        watch_valid = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL b2b_drain: got %0d bins left, expected 0", exp_q.size());
        end
        vectors++;
        if (valid_gaps != 0) begin
            miscompares++; $display("FAIL b2b_bubble: got %0d valid-low cycles, expected 0", valid_gaps);
        end
    endtask

    task automatic test_ready_toggle();
        logic [5+2*W-1:0] held;
        bit               have_held = 1'b0;
        int               stable_checks = 0;
        out_ready = 1'b0;
        send_frame(1, 0, 1'b1, 16);
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            out_ready = (c % 2 == 0);
            @(negedge clk);
            if (!out_ready && out_valid) begin
                held = {out_index, out_re, out_im};
                have_held = 1'b1;
            end else if (out_ready && have_held) begin
                vectors++;
                stable_checks++;
                if ({out_index, out_re, out_im} !== held) begin
                    miscompares++;
                    $display("FAIL toggle_stable: got idx=%0d re=%0h im=%0h, expected idx=%0d re=%0h im=%0h",
                             out_index, out_re, out_im, held[5+2*W-1 -: 5], held[2*W-1:W], held[W-1:0]);
                end
                have_held = 1'b0;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (exp_q.size() != 0 || stable_checks < 16) begin
            miscompares++;
            $display("FAIL toggle_drain: got %0d left and %0d hold checks, expected 0 left and >=16 checks",
                     exp_q.size(), stable_checks);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        send_frame(1, 0, 1'b1, 16);
        send_frame(1, 0, 1'b1, 16);
        send_frame(1, 0, 1'b0, 16);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++; $display("FAIL ovf_held_valid: got %b, expected 1", out_valid);
        end
`ifdef FFT_REORDER_OVF_EN
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++; $display("FAIL ovf_flag: got %b, expected 1", overflow);
        end
`endif
        out_ready = 1'b1;
        wait_drain(200);
        repeat (40) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL ovf_drain: got %0d bins left, expected 0", exp_q.size());
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL ovf_extra_frame: got valid %b, expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b0;
        send_frame(1, 0, 1'b1, 16);
        out_ready = 1'b1;
        send_frame(1, 0, 1'b0, 8);
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_index !== 5'd0) begin
            miscompares++;
            $display("FAIL midrst_async: got valid=%b idx=%0d, expected valid=0 idx=0", out_valid, out_index);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        send_frame(1, 0, 1'b1, 16);
        vectors++;
        if (pre_last_valid !== 1'b0) begin
            miscompares++; $display("FAIL midrst_early_valid: got %b, expected 0", pre_last_valid);
        end
        wait_drain(100);
        repeat (10) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_drain: got %0d left valid=%b, expected 0 left valid=0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_up_re  = '0;
        in_up_im  = '0;
        in_l_re   = '0;
        in_l_im   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_single_frame(0, "single");
        test_back_to_back();
        test_ready_toggle();
        test_overflow();
        pulse_reset();
        test_reset();
        test_reset_mid_frame();
        test_single_frame(2, "gapped");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
